// File: rtl/relogio_pkg.sv
// Shared types and limits for the clock controller and its time counters.
package relogio_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HOUR = 2'b01,
        MODE_SET_MIN  = 2'b10
    } mode_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

endpackage

// File: rtl/relogio_ctrl_btn_edge.sv
// Rising-edge detector for a debounced button level; one pulse per press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;

endmodule

// File: rtl/relogio_ctrl.sv
// Clock sequencing controller: 1 Hz prescaler, seconds counter, minute/hour
// increment pulses and the RUN -> SET_HOUR -> SET_MIN time-setting FSM.
module relogio_ctrl
    import relogio_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BLINK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic       min_max_i,
    output logic [5:0] sec_o,
    output logic       min_inc_o,
    output logic       hour_inc_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);

    localparam int PW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int BLINK_PERIOD = CLK_HZ / BLINK_DIV;
    localparam int BW           = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
    localparam logic [5:0]    SEC_LAST   = 6'(SEC_MAX);

    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic       mode_rise;
    logic       inc_rise;

    assign btn_level = {inc_i, mode_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_edge u_btn_edge (
                .clk   (clk_i),
                .rst   (rst_i),
                .level (btn_level[gi]),
                .rise  (btn_rise[gi])
            );
        end
    endgenerate

    assign mode_rise = btn_rise[0];
    assign inc_rise  = btn_rise[1];

    mode_t         mode_reg, mode_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic [5:0]    sec_reg, sec_next;
    logic          min_inc_reg, min_inc_next;
    logic          hour_inc_reg, hour_inc_next;
    logic          blink_reg, blink_next;
    logic          tick;
    logic          blink_tick;

    assign tick       = (presc_reg == PRESC_LAST);
    assign blink_tick = (blink_cnt_reg == BLINK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_reg      <= MODE_RUN;
            presc_reg     <= '0;
            blink_cnt_reg <= '0;
            sec_reg       <= '0;
            min_inc_reg   <= 1'b0;
            hour_inc_reg  <= 1'b0;
            blink_reg     <= 1'b0;
        end else begin
            mode_reg      <= mode_next;
            presc_reg     <= presc_next;
            blink_cnt_reg <= blink_cnt_next;
            sec_reg       <= sec_next;
            min_inc_reg   <= min_inc_next;
            hour_inc_reg  <= hour_inc_next;
            blink_reg     <= blink_next;
        end
    end

    always_comb begin
        mode_next      = mode_reg;
        presc_next     = tick ? '0 : presc_reg + 1'b1;
        sec_next       = sec_reg;
        min_inc_next   = 1'b0;
        hour_inc_next  = 1'b0;
        blink_cnt_next = '0;
        blink_next     = 1'b0;

        // Blink phase runs on its own counter so SET_HOUR -> SET_MIN keeps the rhythm.
        if (mode_reg != MODE_RUN) begin
            blink_cnt_next = blink_tick ? '0 : blink_cnt_reg + 1'b1;
            blink_next     = blink_tick ? ~blink_reg : blink_reg;
        end

        case (mode_reg)
            MODE_RUN: begin
                if (mode_rise) begin
                    mode_next      = MODE_SET_HOUR;
                    sec_next       = '0;
                    presc_next     = '0;
                    blink_next     = 1'b1;
                    blink_cnt_next = '0;
                end else if (tick) begin
                    if (sec_reg == SEC_LAST) begin
                        sec_next      = '0;
                        min_inc_next  = 1'b1;
                        hour_inc_next = min_max_i;
                    end else begin
                        sec_next = sec_reg + 6'd1;
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (mode_rise) begin
                    mode_next = MODE_SET_MIN;
                end else if (inc_rise) begin
                    hour_inc_next = 1'b1;
                end
            end
            MODE_SET_MIN: begin
                if (mode_rise) begin
                    // Restarting the prescaler puts the first tick CLK_HZ cycles after the edge.
                    mode_next  = MODE_RUN;
                    presc_next = '0;
                    blink_next = 1'b0;
                end else if (inc_rise) begin
                    min_inc_next = 1'b1;
                end
            end
            default: begin
                mode_next = MODE_RUN;
            end
        endcase
    end

    assign sec_o      = sec_reg;
    assign min_inc_o  = min_inc_reg;
    assign hour_inc_o = hour_inc_reg;
    assign mode_o     = mode_reg;
    assign blink_o    = blink_reg;

endmodule

// File: tb/tb_relogio_ctrl.sv
// Directed self-checking bench for relogio_ctrl with CLK_HZ=4, BLINK_DIV=2.
module tb_relogio_ctrl;

    logic       clk;
    logic       rst;
    logic       mode_in;
    logic       inc_in;
    logic       min_max;
    logic [5:0] sec;
    logic       min_inc;
    logic       hour_inc;
    logic [1:0] mode;
    logic       blink;

    int checks   = 0;
    int failures = 0;

    relogio_ctrl #(
        .CLK_HZ    (4),
        .BLINK_DIV (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .mode_i     (mode_in),
        .inc_i      (inc_in),
        .min_max_i  (min_max),
        .sec_o      (sec),
        .min_inc_o  (min_inc),
        .hour_inc_o (hour_inc),
        .mode_o     (mode),
        .blink_o    (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // One posedge passes; outputs are sampled on the following negedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_in = 1'b0; inc_in = 1'b0; min_max = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        checks++;
        if (sec !== 6'd2) begin
            failures++; $display("FAIL reset_precount sec got=%0d exp=2", sec);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sec !== 6'd0 || mode !== 2'b00 || min_inc !== 1'b0 || hour_inc !== 1'b0 || blink !== 1'b0) begin
            failures++;
            $display("FAIL reset_state sec=%0d mode=%0d min=%0b hour=%0b blink=%0b exp all 0",
                     sec, mode, min_inc, hour_inc, blink);
        end
        step();
        rst = 1'b0;
        $display("test_reset done");
    endtask

    // k counts posedges since reset release; seconds = floor(k/4) mod 60.
    task automatic test_run_wrap();
        for (int k = 1; k <= 241; k++) begin
            step();
            checks++;
            if (sec !== 6'((k / 4) % 60)) begin
                failures++; $display("FAIL run_sec k=%0d got=%0d exp=%0d", k, sec, (k / 4) % 60);
            end
            checks++;
            if (min_inc !== (k == 240) || hour_inc !== 1'b0) begin
                failures++; $display("FAIL run_pulse k=%0d min=%0b hour=%0b exp min=%0b hour=0",
                                     k, min_inc, hour_inc, k == 240);
            end
        end
        $display("test_run_wrap done");
    endtask

    task automatic test_run_carry();
        for (int k = 242; k <= 481; k++) begin
            step();
            checks++;
            if (sec !== 6'((k / 4) % 60)) begin
                failures++; $display("FAIL carry_sec k=%0d got=%0d exp=%0d", k, sec, (k / 4) % 60);
            end
            checks++;
            if (min_inc !== (k == 480) || hour_inc !== (k == 480)) begin
                failures++; $display("FAIL carry_pulse k=%0d min=%0b hour=%0b exp both=%0b",
                                     k, min_inc, hour_inc, k == 480);
            end
            min_max = ((k >= 298 && k <= 301) || (k >= 476 && k <= 479)) ? 1'b1 : 1'b0;
        end
        min_max = 1'b0;
        $display("test_run_carry done");
    endtask

    task automatic test_set_modes();
        mode_in = 1'b1;
        step();
        checks++;
        if (mode !== 2'b01 || sec !== 6'd0 || blink !== 1'b1) begin
            failures++; $display("FAIL enter_set_hour mode=%0d sec=%0d blink=%0b exp 1/0/1", mode, sec, blink);
        end
        for (int j = 1; j <= 3; j++) begin
            step();
            checks++;
            if (mode !== 2'b01 || blink !== (j < 2)) begin
                failures++; $display("FAIL set_hour_hold j=%0d mode=%0d blink=%0b exp 1/%0b", j, mode, blink, j < 2);
            end
        end
        mode_in = 1'b0;
        inc_in  = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            checks++;
            if (hour_inc !== (j == 0) || min_inc !== 1'b0 || sec !== 6'd0) begin
                failures++; $display("FAIL hour_inc_hold j=%0d hour=%0b min=%0b sec=%0d exp hour=%0b",
                                     j, hour_inc, min_inc, sec, j == 0);
            end
        end
        inc_in = 1'b0;
        step();
        mode_in = 1'b1;
        step();
        checks++;
        if (mode !== 2'b10 || min_inc !== 1'b0 || hour_inc !== 1'b0) begin
            failures++; $display("FAIL enter_set_min mode=%0d min=%0b hour=%0b exp 2/0/0", mode, min_inc, hour_inc);
        end
        mode_in = 1'b0;
        inc_in  = 1'b1;
        step();
        checks++;
        if (min_inc !== 1'b1 || hour_inc !== 1'b0) begin
            failures++; $display("FAIL set_min_inc min=%0b hour=%0b exp 1/0", min_inc, hour_inc);
        end
        step();
        checks++;
        if (min_inc !== 1'b0 || hour_inc !== 1'b0) begin
            failures++; $display("FAIL set_min_width min=%0b hour=%0b exp 0/0", min_inc, hour_inc);
        end
        inc_in = 1'b0;
        step();
        $display("test_set_modes done");
    endtask

    task automatic test_simultaneous();
        mode_in = 1'b1; step(); mode_in = 1'b0; step();
        mode_in = 1'b1; step();
        checks++;
        if (mode !== 2'b01) begin
            failures++; $display("FAIL simul_setup mode=%0d exp 1", mode);
        end
        mode_in = 1'b0; step();
        mode_in = 1'b1; inc_in = 1'b1;
        for (int j = 0; j < 2; j++) begin
            step();
            checks++;
            if (mode !== 2'b10 || min_inc !== 1'b0 || hour_inc !== 1'b0) begin
                failures++; $display("FAIL simul_edges j=%0d mode=%0d min=%0b hour=%0b exp 2/0/0",
                                     j, mode, min_inc, hour_inc);
            end
        end
        mode_in = 1'b0; inc_in = 1'b0;
        step();
        $display("test_simultaneous done");
    endtask

    task automatic test_return_run();
        mode_in = 1'b1;
        step();
        checks++;
        if (mode !== 2'b00 || blink !== 1'b0 || sec !== 6'd0) begin
            failures++; $display("FAIL return_run mode=%0d blink=%0b sec=%0d exp 0/0/0", mode, blink, sec);
        end
        mode_in = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++;
            if (sec !== 6'(j == 4) || blink !== 1'b0) begin
                failures++; $display("FAIL first_tick j=%0d sec=%0d blink=%0b exp sec=%0d", j, sec, blink, j == 4);
            end
        end
        inc_in = 1'b1;
        for (int j = 0; j < 2; j++) begin
            step();
            checks++;
            if (min_inc !== 1'b0 || hour_inc !== 1'b0 || mode !== 2'b00) begin
                failures++; $display("FAIL run_inc_ignored j=%0d min=%0b hour=%0b mode=%0d exp 0/0/0",
                                     j, min_inc, hour_inc, mode);
            end
        end
        inc_in = 1'b0;
        step();
        $display("test_return_run done");
    endtask

    initial begin
        rst = 1'b1; mode_in = 1'b0; inc_in = 1'b0; min_max = 1'b0;
        @(negedge clk);
        test_reset();
        test_run_wrap();
        test_run_carry();
        test_set_modes();
        test_simultaneous();
        test_return_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
